// File: rtl/rgmii_pkg.sv
// ---------------------------------------------------------------------------
// rgmii_pkg
// Shared types and constants for the RGMII receive adapter.
//   rx_state_t   : nibble-pairing FSM states used in 10/100 mode
//   SPEED_*      : in-band speed codes reported on link_speed
//   CTL_BIT      : index of the RX_CTL bit inside a 5-bit IDDR sample
//   inband_speed : maps the two in-band speed bits onto a SPEED_* code
// ---------------------------------------------------------------------------
package rgmii_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } rx_state_t;

    localparam logic [1:0] SPEED_10   = 2'b00;
    localparam logic [1:0] SPEED_100  = 2'b01;
    localparam logic [1:0] SPEED_1000 = 2'b10;

    localparam int CTL_BIT = 4;

    // Code 2'b11 is reserved on the wire; it is reported unchanged so the
    // MAC can see it rather than having it silently aliased to a valid rate.
    function automatic logic [1:0] inband_speed(input logic [1:0] code);
        logic [1:0] result;
        unique case (code)
            2'b00:   result = SPEED_10;
            2'b01:   result = SPEED_100;
            2'b10:   result = SPEED_1000;
            default: result = code;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/rgmii_inband_status.sv
// ---------------------------------------------------------------------------
// rgmii_inband_status
// Debounces the in-band link status the PHY places on RXD between frames.
// A new value is accepted only when the same nibble is seen on two
// consecutive qualifying cycles; any non-qualifying cycle restarts the match.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   nibble [3:0] : candidate status nibble (rising-edge RXD)
//   qualify      : 1 when the cycle is a plain idle (no dv, no er)
//   link_up      : nibble[0]
//   link_speed   : nibble[2:1] as a SPEED_* code
//   link_duplex  : nibble[3], 1 = full duplex
// ---------------------------------------------------------------------------
module rgmii_inband_status
    import rgmii_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] nibble,
    input  logic       qualify,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       link_duplex
);

    logic [3:0] prev_nib_reg;
    logic       prev_valid_reg;
    logic       link_up_reg;
    logic [1:0] link_speed_reg;
    logic       link_duplex_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_nib_reg    <= 4'h0;
            prev_valid_reg  <= 1'b0;
            link_up_reg     <= 1'b0;
            link_speed_reg  <= 2'b00;
            link_duplex_reg <= 1'b0;
        end else if (qualify) begin
            prev_nib_reg   <= nibble;
            prev_valid_reg <= 1'b1;
            if (prev_valid_reg && (prev_nib_reg == nibble)) begin
                link_up_reg     <= nibble[0];
                link_speed_reg  <= inband_speed(nibble[2:1]);
                link_duplex_reg <= nibble[3];
            end
        end else begin
            prev_valid_reg <= 1'b0;
        end
    end

    assign link_up     = link_up_reg;
    assign link_speed  = link_speed_reg;
    assign link_duplex = link_duplex_reg;

endmodule

// File: rtl/rgmii_rx_adapter.sv
// ---------------------------------------------------------------------------
// rgmii_rx_adapter
// Converts IDDR samples of the RGMII receive interface into a byte-wide
// GMII receive stream qualified by a clock enable.
//   1000 mode : both edges carry data, one byte per clk, ce always 1.
//   10/100    : one nibble per clk (rising sample only); nibbles are paired
//               low-first into bytes, ce marks the cycles carrying a byte.
// Ports:
//   clk, rst_n        : RGMII rx clock, asynchronous active-low reset
//   iddr_q1 [4:0]     : rising-edge sample  {ctl, rxd[3:0]}
//   iddr_q2 [4:0]     : falling-edge sample {ctl, rxd[3:0]}
//   speed_1000        : requested mode, taken only between frames
//   gmii_rxd [7:0]    : assembled byte
//   gmii_rx_dv/_er    : data valid / receive error
//   gmii_rx_ce        : outputs above are meaningful only when high
//   link_up/link_speed/link_duplex : in-band status from inter-frame gaps
//   odd_nibble_err    : one-cycle pulse when a 10/100 frame ends unpaired
// ---------------------------------------------------------------------------
module rgmii_rx_adapter
    import rgmii_pkg::*;
#(
    parameter bit INBAND_STATUS_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] iddr_q1,
    input  logic [4:0] iddr_q2,
    input  logic       speed_1000,
    output logic [7:0] gmii_rxd,
    output logic       gmii_rx_dv,
    output logic       gmii_rx_er,
    output logic       gmii_rx_ce,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       link_duplex,
    output logic       odd_nibble_err
);

    // RX_CTL carries dv on the rising edge and dv^er on the falling edge.
    logic       dv;
    logic       er;
    logic [3:0] nib;

    assign dv  = iddr_q1[CTL_BIT];
    assign er  = iddr_q1[CTL_BIT] ^ iddr_q2[CTL_BIT];
    assign nib = iddr_q1[3:0];

    rx_state_t  state_reg;
    logic       mode_reg;       // 1 = gigabit DDR
    logic       wait_idle_reg;  // set by reset: ignore a frame already in flight
    logic [3:0] low_nib_reg;
    logic       low_er_reg;
    logic [7:0] rxd_reg;
    logic       dv_reg;
    logic       er_reg;
    logic       ce_reg;
    logic       odd_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            mode_reg      <= 1'b1;
            wait_idle_reg <= 1'b1;
            low_nib_reg   <= 4'h0;
            low_er_reg    <= 1'b0;
            rxd_reg       <= 8'h00;
            dv_reg        <= 1'b0;
            er_reg        <= 1'b0;
            ce_reg        <= 1'b0;
            odd_reg       <= 1'b0;
        end else begin
            odd_reg <= 1'b0;

            // Mode changes only between frames so a frame is never split
            // across two decoding schemes.
            if ((state_reg == IDLE) && !dv) begin
                mode_reg <= speed_1000;
            end

            if (wait_idle_reg && dv) begin
                // Tail of a frame that began before reset: drop it silently.
                ce_reg <= 1'b0;
            end else begin
                wait_idle_reg <= 1'b0;
                if (mode_reg) begin
                    rxd_reg <= {iddr_q2[3:0], iddr_q1[3:0]};
                    dv_reg  <= dv;
                    er_reg  <= er;
                    ce_reg  <= 1'b1;
                end else begin
                    unique case (state_reg)
                        IDLE: begin
                            ce_reg  <= 1'b1;
                            dv_reg  <= 1'b0;
                            er_reg  <= er;
                            rxd_reg <= {nib, nib};
                            if (dv) begin
                                low_nib_reg <= nib;
                                low_er_reg  <= er;
                                state_reg   <= HIGH;
                            end
                        end
                        HIGH: begin
                            ce_reg <= 1'b1;
                            dv_reg <= 1'b1;
                            if (dv) begin
                                rxd_reg   <= {nib, low_nib_reg};
                                er_reg    <= low_er_reg | er;
                                state_reg <= LOW;
                            end else begin
                                // Frame ended on an unpaired nibble: flush it
                                // as an errored byte.
                                rxd_reg   <= {4'h0, low_nib_reg};
                                er_reg    <= 1'b1;
                                odd_reg   <= 1'b1;
                                state_reg <= IDLE;
                            end
                        end
                        LOW: begin
                            if (dv) begin
                                ce_reg      <= 1'b0;
                                low_nib_reg <= nib;
                                low_er_reg  <= er;
                                state_reg   <= HIGH;
                            end else begin
                                // End-of-frame marker: a qualified non-dv cycle.
                                ce_reg    <= 1'b1;
                                dv_reg    <= 1'b0;
                                er_reg    <= 1'b0;
                                rxd_reg   <= {nib, nib};
                                state_reg <= IDLE;
                            end
                        end
                        default: state_reg <= IDLE;
                    endcase
                end
            end
        end
    end

    assign gmii_rxd       = rxd_reg;
    assign gmii_rx_dv     = dv_reg;
    assign gmii_rx_er     = er_reg;
    assign gmii_rx_ce     = ce_reg;
    assign odd_nibble_err = odd_reg;

    generate
        if (INBAND_STATUS_EN) begin : g_inband
            rgmii_inband_status u_status (
                .clk         (clk),
                .rst_n       (rst_n),
                .nibble      (nib),
                .qualify     (!dv && !er),
                .link_up     (link_up),
                .link_speed  (link_speed),
                .link_duplex (link_duplex)
            );
        end else begin : g_no_inband
            assign link_up     = 1'b0;
            assign link_speed  = 2'b00;
            assign link_duplex = 1'b0;
        end
    endgenerate

endmodule

// File: doc/rgmii_rx_adapter.md
Name: rgmii_rx_adapter

Overview:
Consumes the 5-bit-wide IDDR outputs ({RX_CTL, RXD[3:0]} per edge) on the RGMII receive path and produces a byte-wide GMII receive stream with a clock-enable qualifier.
Handles 1000 Mb/s DDR (two nibbles per clk) and 10/100 Mb/s SDR (one nibble per clk; nibbles are paired into bytes).
Decodes RGMII RX_CTL into rx_dv/rx_er and extracts in-band link status during inter-frame gaps.
Sits between the IDDR stage and the GMII MAC receive logic.

Parameters:
INBAND_STATUS_EN, 1, 1 = decode in-band status from RXD during idle; 0 = status outputs held at reset values.

Ports:
clk  input  1  RGMII rx clock, the same clock that drives the IDDR.
rst_n  input  1  asynchronous active-low reset.
iddr_q1  input  5  rising-edge sample {ctl, rxd[3:0]}.
iddr_q2  input  5  falling-edge sample {ctl, rxd[3:0]}.
speed_1000  input  1  1 = gigabit DDR mode; 0 = 10/100 nibble mode.
gmii_rxd  output  8  assembled receive byte.
gmii_rx_dv  output  1  data valid.
gmii_rx_er  output  1  receive error.
gmii_rx_ce  output  1  clock enable; the outputs above are meaningful only when it is high.
link_up  output  1  in-band link status.
link_speed  output  2  in-band speed: 00 = 10, 01 = 100, 10 = 1000.
link_duplex  output  1  in-band duplex: 1 = full.
odd_nibble_err  output  1  one-cycle pulse when a 10/100 frame ends on an unpaired nibble.

Behaviour:
- Reset (async on rst_n low): all outputs 0. State returns to IDLE. Latched mode = 1000.
- Per-edge decode:
  - dv = q1[4].
  - er = q1[4] ^ q2[4], per RGMII CTL encoding.
- Mode latch: speed_1000 is sampled into mode_r only when the FSM is in IDLE and the decoded dv is 0. A change mid-frame takes effect after the frame ends.
- 1000 mode (mode_r = 1):
  - gmii_rxd <= {q2[3:0], q1[3:0]}.
  - gmii_rx_dv <= dv.
  - gmii_rx_er <= er.
  - gmii_rx_ce <= 1 every cycle.
  - Latency is 1 clk from the iddr inputs.
- 10/100 mode (mode_r = 0): only q1 is used (both edges carry the same nibble). The FSM has three states:
  - IDLE: each cycle, output ce = 1 with dv = 0, er = q1[4]^q2[4], rxd = {q1[3:0], q1[3:0]}. On dv = 1, capture the nibble as the low half and go to HIGH.
  - HIGH: if dv = 1, emit rxd = {q1[3:0], low}, dv = 1, er = er_low | er_cur, ce = 1, then go to LOW.
  - HIGH, dv = 0 (odd nibble count): emit rxd = {4'h0, low}, dv = 1, er = 1, ce = 1, pulse odd_nibble_err, then go to IDLE.
  - LOW: ce = 0. If dv = 1, capture the low nibble and go to HIGH. If dv = 0, go to IDLE; in that same cycle output ce = 1, dv = 0, er = 0 as the end-of-frame marker.
  - Byte output appears 1 clk after the high nibble arrives. Steady-state ce duty cycle is 50%.
- False carrier / carrier extension (dv = 0, er = 1): passed through with dv = 0, er = 1 in both modes. This never starts nibble pairing.
- In-band status (INBAND_STATUS_EN = 1):
  - Candidate nibble = q1[3:0], sampled only when dv = 0 and er = 0.
  - Status updates only when the same candidate is seen on 2 consecutive qualifying cycles.
  - Mapping: link_up = nib[0], link_speed = nib[2:1], link_duplex = nib[3].
  - Any cycle with dv or er set clears the match history.
- Reset mid-frame: outputs clear immediately. After release, the FSM waits for dv = 0 before accepting a new frame; a partial frame is never emitted.

Decomposition:
- Package rgmii_pkg holds:
  - the FSM state enum: IDLE, LOW, HIGH;
  - the speed code constants: SPEED_10, SPEED_100, SPEED_1000;
  - the CTL field index constant: CTL_BIT = 4.
- The in-band status debouncer is a natural sub-module: rgmii_inband_status (inputs: nibble, qualify; outputs: link fields).

Test Plan:
- 1000 mode, q1 = 5'h15, q2 = 5'h1D for 8 cycles -> gmii_rxd = 8'hD5, dv = 1, er = 0, ce = 1 each cycle, 1 clk latency.
- 1000 mode, q1 = 5'h10, q2 = 5'h00 -> er = 1, dv = 1. Then q1 = 5'h0F, q2 = 5'h1F (dv = 0, er = 1) -> dv = 0, er = 1, rxd = 8'hFF.
- 10/100 mode, nibble sequence 5,5,D,A with ctl = 1 -> two bytes 8'h55, 8'hAD. ce pulses on alternate cycles. End-of-frame marker ce = 1, dv = 0 when ctl drops.
- 10/100 mode, 3 nibbles 1,2,3 then ctl = 0 -> bytes 8'h21, then 8'h03 with er = 1, and odd_nibble_err pulses once.
- Idle with q1 = q2 = 5'h0D for 2 cycles -> link_up = 1, link_speed = 2'b10, link_duplex = 1. A single cycle of 5'h00 between them -> no update.
- speed_1000 toggled mid-frame, then rst_n asserted mid-frame -> mode unchanged until dv = 0. On reset, all outputs are 0 asynchronously, and no byte is emitted until a fresh dv rise.
